// File: rtl/tile_rom_arbiter.sv
// Shares one pipelined tile/sprite ROM among N_REQ requesters: requester 0 (pixel mapper)
// wins outright during the visible area, the rest are served round-robin.
module tile_rom_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic                      display_active,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             rr_grant;
    int               scan_i;
    logic [N_REQ-1:0] tag_pipe [ROM_LAT];

    // Grants are gated by reset_n so nothing reaches the ROM while reset is held.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        rr_grant = 1'b0;
        scan_i   = 0;
        scan_idx = '0;
        if (reset_n) begin
            if (display_active && req[0]) begin
                gnt[0] = 1'b1;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    scan_i = int'(ptr) + k;
                    if (scan_i >= N_REQ) begin
                        scan_i = scan_i - N_REQ;
                    end
                    scan_idx = IDX_W'(scan_i);
                    if (!rr_grant && req[scan_idx]) begin
                        gnt[scan_idx] = 1'b1;
                        gnt_idx       = scan_idx;
                        rr_grant      = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                rom_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Priority grants leave the pointer alone so RR order resumes after the visible line.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= IDX_W'(1);
        end else if (rr_grant) begin
            if (gnt_idx == IDX_W'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= gnt;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            busy = busy | (|tag_pipe[i]);
        end
    end

    assign rd_valid = tag_pipe[ROM_LAT-1];
    assign rd_data  = rom_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Bench for tile_rom_arbiter: directed vector table, hand sequences for reset/latency/withdrawal,
// and random traffic checked against a queue-based reference model.
module tb_tile_rom_arbiter;

    localparam int N   = 3;
    localparam int AW  = 15;
    localparam int DW  = 4;
    localparam int LAT = 2;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic              display_active;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_q;
    logic [N-1:0]      rd_valid;
    logic [DW-1:0]     rd_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    tile_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .vga_clk        (vga_clk),
        .reset_n        (reset_n),
        .display_active (display_active),
        .req            (req),
        .req_addr       (req_addr),
        .gnt            (gnt),
        .rom_addr       (rom_addr),
        .rom_q          (rom_q),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM model: registered address, LAT-cycle read, q = addr[3:0]
    logic [AW-1:0] rom_pipe [LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[LAT-1][3:0];

    typedef struct {
        int            cyc;
        int            idx;
        logic [AW-1:0] addr;
    } flight_t;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  rdv;
        logic [DW-1:0] rdata;
        logic          busy;
        logic [AW-1:0] raddr;
    } samp_t;

    typedef struct packed {
        logic         da;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [N-1:0] rdv;
    } vec_t;

    flight_t inflight[$];
    int      ptr_m = 1;
    int      cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_grant(input logic da, input logic [N-1:0] r, input int p);
        if (da && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] slice_addr(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    // One cycle: sample at negedge, compare with the model, advance the model, return at posedge+1.
    task automatic tick(output samp_t s);
        int            g;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rdv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_busy;
        @(negedge vga_clk);
        s.gnt   = gnt;
        s.rdv   = rd_valid;
        s.rdata = rd_data;
        s.busy  = busy;
        s.raddr = rom_addr;
        e_gnt  = '0;
        e_rdv  = '0;
        e_addr = '0;
        e_data = '0;
        e_busy = 1'b0;
        if (!reset_n) begin
            inflight.delete();
            ptr_m = 1;
        end else begin
            while (inflight.size() > 0 && inflight[0].cyc < cyc - LAT) inflight.delete(0);
            e_busy = (inflight.size() > 0);
            if (inflight.size() > 0 && inflight[0].cyc == cyc - LAT) begin
                e_rdv[inflight[0].idx] = 1'b1;
                e_data = inflight[0].addr[3:0];
            end
            g = model_grant(display_active, req, ptr_m);
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_addr   = slice_addr(g);
                inflight.push_back('{cyc: cyc, idx: g, addr: e_addr});
                if (!(display_active && req[0])) ptr_m = (g + 1) % N;
            end
        end
        chk("gnt", 32'(s.gnt), 32'(e_gnt));
        chk("rom_addr", 32'(s.raddr), 32'(e_addr));
        chk("rd_valid", 32'(s.rdv), 32'(e_rdv));
        chk("busy", 32'(s.busy), 32'(e_busy));
        if (e_rdv != '0) chk("rd_data", 32'(s.rdata), 32'(e_data));
        cyc++;
        @(posedge vga_clk);
        #1;
    endtask

    vec_t  tbl[13];
    samp_t s;
    logic  seen1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 3'b111, 3'b010, 3'b000};
        tbl[1]  = '{1'b0, 3'b111, 3'b100, 3'b000};
        tbl[2]  = '{1'b0, 3'b111, 3'b001, 3'b010};
        tbl[3]  = '{1'b0, 3'b111, 3'b010, 3'b100};
        tbl[4]  = '{1'b0, 3'b111, 3'b100, 3'b001};
        tbl[5]  = '{1'b0, 3'b111, 3'b001, 3'b010};
        tbl[6]  = '{1'b1, 3'b111, 3'b001, 3'b100};
        tbl[7]  = '{1'b1, 3'b111, 3'b001, 3'b001};
        tbl[8]  = '{1'b1, 3'b111, 3'b001, 3'b001};
        tbl[9]  = '{1'b1, 3'b111, 3'b001, 3'b001};
        tbl[10] = '{1'b0, 3'b111, 3'b010, 3'b001};
        tbl[11] = '{1'b0, 3'b000, 3'b000, 3'b001};
        tbl[12] = '{1'b0, 3'b000, 3'b000, 3'b010};

        reset_n        = 1'b0;
        display_active = 1'b0;
        req            = 3'b111;
        req_addr       = '0;
        req_addr[0*AW +: AW] = 15'h001;
        req_addr[1*AW +: AW] = 15'h012;
        req_addr[2*AW +: AW] = 15'h0A5;

        // Reset with all requests pending
        #1;
        tick(s);
        chk("rst_gnt", 32'(s.gnt), 32'h0);
        chk("rst_rom_addr", 32'(s.raddr), 32'h0);
        chk("rst_busy", 32'(s.busy), 32'h0);
        tick(s);
        reset_n = 1'b1;

        // Round-robin, priority and resume
        for (int i = 0; i < 13; i++) begin
            display_active = tbl[i].da;
            req            = tbl[i].req;
            tick(s);
            chk($sformatf("tbl%0d_gnt", i), 32'(s.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rdv", i), 32'(s.rdv), 32'(tbl[i].rdv));
        end

        // Latency and data for req2
        req = 3'b100;
        tick(s);
        chk("lat_gnt", 32'(s.gnt), 32'h4);
        chk("lat_addr", 32'(s.raddr), 32'h0A5);
        req = 3'b000;
        tick(s);
        chk("lat_early", 32'(s.rdv), 32'h0);
        tick(s);
        chk("lat_rdv", 32'(s.rdv), 32'h4);
        chk("lat_data", 32'(s.rdata), 32'h5);
        tick(s);

        // Back-to-back issues stay in order
        req = 3'b011;
        tick(s);
        tick(s);
        req = 3'b000;
        tick(s);
        tick(s);
        tick(s);

        // Reset while a read is in flight
        req = 3'b010;
        tick(s);
        chk("mid_gnt", 32'(s.gnt), 32'h2);
        reset_n = 1'b0;
        req = 3'b000;
        #1;
        chk("mid_busy_clr", 32'(busy), 32'h0);
        tick(s);
        tick(s);
        chk("mid_no_rdv", 32'(s.rdv), 32'h0);
        reset_n = 1'b1;
        tick(s);
        chk("post_rst_busy", 32'(s.busy), 32'h0);
        tick(s);
        chk("post_rst_rdv", 32'(s.rdv), 32'h0);

        // Withdrawal under priority, then idle drain
        display_active = 1'b1;
        seen1 = 1'b0;
        req = 3'b001;
        tick(s);
        seen1 = seen1 | s.gnt[1] | s.rdv[1];
        req = 3'b011;
        tick(s);
        seen1 = seen1 | s.gnt[1] | s.rdv[1];
        req = 3'b001;
        tick(s);
        seen1 = seen1 | s.gnt[1] | s.rdv[1];
        req = 3'b000;
        display_active = 1'b0;
        tick(s);
        seen1 = seen1 | s.gnt[1] | s.rdv[1];
        chk("idle_addr", 32'(s.raddr), 32'h0);
        chk("drain_busy1", 32'(s.busy), 32'h1);
        tick(s);
        seen1 = seen1 | s.gnt[1] | s.rdv[1];
        chk("drain_busy2", 32'(s.busy), 32'h1);
        tick(s);
        chk("drain_busy0", 32'(s.busy), 32'h0);
        chk("withdrawn_req1", 32'(seen1), 32'h0);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            display_active = ($urandom_range(0, 3) == 0);
            req            = N'($urandom);
            for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
            reset_n        = ($urandom_range(0, 99) != 0);
            tick(s);
        end
        reset_n = 1'b1;
        req     = '0;
        for (int n = 0; n < LAT + 2; n++) tick(s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
